// File: rtl/blc_core.sv
`default_nettype none
// ============================================================================
//  Module   : blc_core
//  Purpose  : Black level calibration datapath. Subtracts a manual or measured
//             black level (saturating at zero) from a one-pixel-per-beat
//             AXI4-Stream video path. The measured level is the mean of the
//             first 2^CAL_LOG2 pixels of a frame.
//  Revision : 1.0 - initial release
// ============================================================================
module blc_core #(
    parameter int PX_WIDTH    = 10,
    parameter int TDATA_WIDTH = 16,
    parameter int CAL_LOG2    = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mode_i,
    input  logic                   cal_stb_i,
    input  logic [31:0]            man_bl_i,
    output logic [31:0]            cur_bl_o,
    output logic                   cal_busy_o,
    input  logic [TDATA_WIDTH-1:0] video_i_tdata,
    input  logic                   video_i_tvalid,
    output logic                   video_i_tready,
    input  logic                   video_i_tuser,
    input  logic                   video_i_tlast,
    output logic [TDATA_WIDTH-1:0] video_o_tdata,
    output logic                   video_o_tvalid,
    input  logic                   video_o_tready,
    output logic                   video_o_tuser,
    output logic                   video_o_tlast
);

    localparam int                c_acc_w   = PX_WIDTH + CAL_LOG2;
    localparam logic [CAL_LOG2:0] c_cnt_one = (CAL_LOG2 + 1)'(1);
    localparam logic [CAL_LOG2:0] c_cal_n   = c_cnt_one << CAL_LOG2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_ACC      = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic                     r_out_valid;
    logic [TDATA_WIDTH-1:0]   r_out_data;
    logic                     r_out_user;
    logic                     r_out_last;
    logic [PX_WIDTH-1:0]      r_applied_bl;
    logic [PX_WIDTH-1:0]      r_cal_bl;
    logic [c_acc_w-1:0]       r_acc;
    logic [CAL_LOG2:0]        r_cnt;

    logic                     w_in_ready;
    logic                     w_in_hs;
    logic                     w_sof_hs;
    logic [PX_WIDTH-1:0]      w_px;
    logic [PX_WIDTH-1:0]      w_target_bl;
    logic [PX_WIDTH-1:0]      w_bl;
    logic [PX_WIDTH:0]        w_diff;
    logic [PX_WIDTH-1:0]      w_corr;
    logic                     w_acc_load;
    logic                     w_acc_add;
    logic [CAL_LOG2:0]        w_cnt_nxt;
    logic [c_acc_w-1:0]       w_acc_nxt;
    logic                     w_unused_bits;

    assign w_in_ready  = !r_out_valid || video_o_tready;
    assign w_in_hs     = video_i_tvalid && w_in_ready;
    assign w_sof_hs    = w_in_hs && video_i_tuser;
    assign w_px        = video_i_tdata[PX_WIDTH-1:0];
    assign w_target_bl = mode_i ? r_cal_bl : man_bl_i[PX_WIDTH-1:0];

    // The SOF beat already sees the newly selected level.
    assign w_bl   = w_sof_hs ? w_target_bl : r_applied_bl;
    assign w_diff = {1'b0, w_px} - {1'b0, w_bl};
    assign w_corr = w_diff[PX_WIDTH] ? '0 : w_diff[PX_WIDTH-1:0];

    assign w_unused_bits = ^{man_bl_i, video_i_tdata};

    // ------------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_user   <= 1'b0;
            r_out_last   <= 1'b0;
            r_applied_bl <= '0;
        end else begin
            if (w_in_hs) begin
                r_out_valid <= 1'b1;
                r_out_data  <= TDATA_WIDTH'(w_corr);
                r_out_user  <= video_i_tuser;
                r_out_last  <= video_i_tlast;
            end else if (video_o_tready) begin
                r_out_valid <= 1'b0;
            end
            if (w_sof_hs) begin
                r_applied_bl <= w_target_bl;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Calibration FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_load  = 1'b0;
        w_acc_add   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cal_stb_i) begin
                    w_state_nxt = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (w_sof_hs) begin
                    w_acc_load  = 1'b1;
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                // A new SOF inside the window means the frame was too short.
                if (w_sof_hs) begin
                    w_acc_load = 1'b1;
                end else if (w_in_hs) begin
                    w_acc_add = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cnt_nxt = w_acc_load ? c_cnt_one : r_cnt + c_cnt_one;
        w_acc_nxt = w_acc_load ? c_acc_w'(w_px) : r_acc + c_acc_w'(w_px);
        if ((w_acc_load || w_acc_add) && (w_cnt_nxt == c_cal_n)) begin
            w_state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_cal_bl <= '0;
        end else begin
            if (w_acc_load || w_acc_add) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
            end
            if (r_state == S_DONE) begin
                r_cal_bl <= r_acc[c_acc_w-1:CAL_LOG2];
            end
        end
    end

    assign video_i_tready = w_in_ready;
    assign video_o_tvalid = r_out_valid;
    assign video_o_tdata  = r_out_data;
    assign video_o_tuser  = r_out_user;
    assign video_o_tlast  = r_out_last;
    assign cur_bl_o       = 32'(r_applied_bl);
    assign cal_busy_o     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/blc_core.md
Name: blc_core

Overview:
Black level calibration datapath. Sits directly downstream of the BLC CSR block: consumes its mode / calibration strobe / manual black level controls and returns the currently applied black level for the status register. Processes one pixel per beat on an AXI4-Stream video path, subtracting the black level with saturation at zero. In auto mode it measures the black level by averaging the first 2^CAL_LOG2 pixels of a frame.

Parameters:
PX_WIDTH, 10, pixel bit width, valid range 8..16
TDATA_WIDTH, 16, stream tdata width, must be >= PX_WIDTH; upper bits are zero on output
CAL_LOG2, 10, log2 of the number of pixels averaged per calibration

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mode_i  in  1  0 = manual black level, 1 = auto (calibrated) black level
cal_stb_i  in  1  single-cycle pulse that requests a calibration
man_bl_i  in  32  manual black level; only [PX_WIDTH-1:0] is used
cur_bl_o  out  32  black level currently applied, zero-extended
cal_busy_o  out  1  calibration in progress
video_i_tdata  in  TDATA_WIDTH  input pixel in [PX_WIDTH-1:0]
video_i_tvalid  in  1  input valid
video_i_tready  out  1  input ready
video_i_tuser  in  1  start of frame
video_i_tlast  in  1  end of line
video_o_tdata  out  TDATA_WIDTH  corrected pixel
video_o_tvalid  out  1  output valid
video_o_tready  in  1  output ready
video_o_tuser  out  1  start of frame, passed through
video_o_tlast  out  1  end of line, passed through

Behaviour:
- Reset (synchronous, rst_i high at a clock edge): video_o_* = 0, cur_bl_o = 0, cal_busy_o = 0, cal_bl = 0, accumulator = 0, FSM = IDLE. Reset mid-calibration or mid-frame aborts the operation; no partial result is kept.
- Input beat: in_hs = video_i_tvalid && video_i_tready.
- Pipeline: one register stage, latency 1 cycle from in_hs to video_o_tvalid. video_i_tready = !video_o_tvalid || video_o_tready. The output holds tdata, tuser and tlast stable while video_o_tvalid && !video_o_tready. video_o_tvalid clears on an output handshake that has no new in_hs in the same cycle.
- Black level select: target_bl = mode_i ? cal_bl : man_bl_i[PX_WIDTH-1:0].
- Applied black level (applied_bl) updates only on an in_hs beat with tuser = 1, and that SOF pixel already uses the new value. Changes to mode_i, man_bl_i or cal_bl mid-frame are deferred to the next SOF.
- cur_bl_o = zero-extended applied_bl.
- Output pixel = (px > applied_bl) ? px - applied_bl : 0. The subtraction is computed on PX_WIDTH+1 bits, with no wrap-around.
- Calibration FSM:
  - IDLE: cal_stb_i -> WAIT_SOF.
  - WAIT_SOF: an in_hs with tuser -> ACC; on entry acc = px and cnt = 1.
  - ACC: on each in_hs, acc += px and cnt++. When cnt reaches 2^CAL_LOG2 after the add -> DONE. If an in_hs carries tuser while in ACC (frame shorter than the window), accumulation restarts with acc = px and cnt = 1.
  - DONE (1 cycle): cal_bl = acc >> CAL_LOG2 (truncating) -> IDLE.
- Accumulator width is PX_WIDTH+CAL_LOG2 bits and cannot overflow. cnt width is CAL_LOG2+1 bits.
- cal_busy_o = 1 in WAIT_SOF, ACC and DONE.
- cal_stb_i is ignored while busy, including in the DONE cycle.
- Calibration runs regardless of mode_i. cal_bl only takes effect when mode_i = 1, at the next SOF.
- Calibration samples pixels before subtraction. Backpressure stalls accumulation because accumulation is gated by in_hs.

Test Plan:
- Manual subtraction: mode = 0, man_bl = 64, frame of px = 100, 64, 10 -> out 36, 0, 0; cur_bl_o = 64 from the SOF beat onward; latency 1 cycle; tuser/tlast aligned.
- Auto calibration (CAL_LOG2 = 2 in the bench): cal_stb pulse, then a frame with px 16, 17, 18, 21 -> cal_bl = 18, cal_busy_o high until the DONE cycle. Next SOF with mode = 1 and px 40 -> out 22, cur_bl_o = 18.
- Deferred update: change man_bl 10 -> 30 mid-frame -> the rest of that frame still subtracts 10; the next SOF pixel uses 30.
- Busy/short frame: second cal_stb during ACC is ignored. A new SOF after 2 of 4 pixels restarts the accumulation -> result is the average of the new frame's first 4 pixels only.
- Backpressure: random video_o_tready duty of 30%, 1000 beats -> no loss, no duplication, and output held stable during stalls. Compare against a reference model.
- Reset mid-ACC: rst_i asserted for 1 cycle -> cal_busy_o = 0, cur_bl_o = 0, cal_bl = 0, video_o_tvalid = 0 on the next cycle.
